// File: rtl/segment_swapchain.sv
// segment_swapchain: decides the cycle on which the read segment flips and
// drives SEGMENT / SWAP / STOP / BUSY to the downstream sample/index generator.
//
// Optional feature macro: AUTD3_TRANSITION_GPIO_EN
//   defined     -> transition mode 0x02 (GPIO rising edge) is supported
//   not defined -> mode 0x02 is discarded like any unknown mode, and the
//                  GPIO edge registers are not built
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN_INF | playing the active segment forever, LOOP_END ignored
// RUN_FIN | playing the active segment, counter decrements on LOOP_END
// STOPPED | finite repeat exhausted, STOP held until the next request fires
// WAIT    | request pending; prev_q keeps tracking the run still in progress
module segment_swapchain #(
  parameter int SysTimeWidth = 56,
  parameter int RepWidth     = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    UPDATE_SETTINGS,
  input  logic                    REQ_RD_SEGMENT,
  input  logic [RepWidth-1:0]     REP,
  input  logic [7:0]              TRANSITION_MODE,
  input  logic [63:0]             TRANSITION_VALUE,
  input  logic [SysTimeWidth-1:0] SYS_TIME,
  input  logic                    SYNC_IDX_ZERO,
  input  logic                    LOOP_END,
  input  logic [3:0]              GPIO_IN,
  output logic                    SEGMENT,
  output logic                    SWAP,
  output logic                    STOP,
  output logic                    BUSY
);

  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;

  typedef enum logic [1:0] {
    RUN_INF = 2'd0,
    RUN_FIN = 2'd1,
    STOPPED = 2'd2,
    WAIT    = 2'd3
  } state_e;

  state_e state_q, state_d;
  state_e prev_q, prev_d;
  state_e run_cur, run_nxt;

  logic [RepWidth-1:0]     cnt_q, cnt_d;
  logic                    seg_q, seg_d;
  logic                    swap_q, swap_d;
  logic                    stop_q, stop_d;
  logic                    busy_q, busy_d;

  logic                    req_seg_q;
  logic [RepWidth-1:0]     req_rep_q;
  logic [7:0]              req_mode_q;
  logic [SysTimeWidth-1:0] req_val_q;

  logic                    mode_valid;
  logic                    upd_accept;
  logic                    gpio_rise;
  logic                    trigger;

  // Only the low SysTimeWidth bits of the transition value are ever compared.
  logic unused_inputs;

  // Decode which transition modes this build accepts.
  always_comb begin
    mode_valid = 1'b0;
    case (TRANSITION_MODE)
      MODE_SYNC_IDX: mode_valid = 1'b1;
      MODE_SYS_TIME: mode_valid = 1'b1;
      MODE_EXT:      mode_valid = 1'b1;
`ifdef AUTD3_TRANSITION_GPIO_EN
      MODE_GPIO:     mode_valid = 1'b1;
`endif
      default:       mode_valid = 1'b0;
    endcase
  end

  assign upd_accept = UPDATE_SETTINGS & mode_valid;

`ifdef AUTD3_TRANSITION_GPIO_EN
  logic [3:0] gpio_q;

  // Previous GPIO level, sampled every cycle so a level already high never fires.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gpio_q <= 4'b0;
    end else begin
      gpio_q <= GPIO_IN;
    end
  end

  assign gpio_rise     = GPIO_IN[req_val_q[1:0]] & ~gpio_q[req_val_q[1:0]];
  assign unused_inputs = ^TRANSITION_VALUE[63:SysTimeWidth];
`else
  assign gpio_rise     = 1'b0;
  assign unused_inputs = ^{GPIO_IN, TRANSITION_VALUE[63:SysTimeWidth]};
`endif

  // Latch the request fields whenever a strobe with a supported mode arrives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_seg_q  <= 1'b0;
      req_rep_q  <= '0;
      req_mode_q <= MODE_SYNC_IDX;
      req_val_q  <= '0;
    end else if (upd_accept) begin
      req_seg_q  <= REQ_RD_SEGMENT;
      req_rep_q  <= REP;
      req_mode_q <= TRANSITION_MODE;
      req_val_q  <= TRANSITION_VALUE[SysTimeWidth-1:0];
    end
  end

  // Trigger condition for the pending request, by latched mode.
  always_comb begin
    trigger = 1'b0;
    case (req_mode_q)
      MODE_SYNC_IDX: trigger = SYNC_IDX_ZERO;
      MODE_SYS_TIME: trigger = (SYS_TIME >= req_val_q);
      MODE_GPIO:     trigger = gpio_rise;
      MODE_EXT:      trigger = LOOP_END | stop_q;
      default:       trigger = 1'b0;
    endcase
  end

  // Next-state: run counting (also during WAIT), then request/trigger handling.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    swap_d  = 1'b0;
    stop_d  = stop_q;
    busy_d  = busy_q;

    // The run in progress keeps counting whether or not a request is pending.
    run_cur = (state_q == WAIT) ? prev_q : state_q;
    run_nxt = run_cur;
    if (run_cur == RUN_FIN && LOOP_END) begin
      if (cnt_q == '0) begin
        stop_d  = 1'b1;
        run_nxt = STOPPED;
      end else begin
        cnt_d = cnt_q - RepWidth'(1);
      end
    end

    if (upd_accept) begin
      // A new request beats a simultaneous trigger of the old one.
      state_d = WAIT;
      prev_d  = run_nxt;
      busy_d  = 1'b1;
    end else if (state_q == WAIT && trigger) begin
      // LOOP_END in this cycle belongs to the swap, so the counter is reloaded.
      seg_d  = req_seg_q;
      swap_d = 1'b1;
      stop_d = 1'b0;
      busy_d = 1'b0;
      cnt_d  = req_rep_q;
      if (&req_rep_q) begin
        state_d = RUN_INF;
      end else begin
        state_d = RUN_FIN;
      end
      prev_d = state_d;
    end else if (state_q == WAIT) begin
      prev_d = run_nxt;
    end else begin
      state_d = run_nxt;
    end
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN_INF;
      prev_q  <= RUN_INF;
      cnt_q   <= '0;
      seg_q   <= 1'b0;
      swap_q  <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      swap_q  <= swap_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
    end
  end

  assign SEGMENT = seg_q;
  assign SWAP    = swap_q;
  assign STOP    = stop_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_segment_swapchain.sv
// Directed bench for segment_swapchain. Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point, i.e. they show the
// result of the edge that just sampled the previous input values.
module tb_segment_swapchain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update = 1'b0;
  logic        req_seg = 1'b0;
  logic [15:0] rep = 16'h0;
  logic [7:0]  mode = 8'h0;
  logic [63:0] val = 64'h0;
  logic [55:0] sys_time = 56'h0;
  logic        sync_zero = 1'b0;
  logic        loop_end = 1'b0;
  logic [3:0]  gpio = 4'h0;
  logic        segment, swap, stop, busy;

  int checks = 0;
  int errors = 0;
  logic exp_seg;

  segment_swapchain #(.SysTimeWidth(56), .RepWidth(16)) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .UPDATE_SETTINGS  (update),
    .REQ_RD_SEGMENT   (req_seg),
    .REP              (rep),
    .TRANSITION_MODE  (mode),
    .TRANSITION_VALUE (val),
    .SYS_TIME         (sys_time),
    .SYNC_IDX_ZERO    (sync_zero),
    .LOOP_END         (loop_end),
    .GPIO_IN          (gpio),
    .SEGMENT          (segment),
    .SWAP             (swap),
    .STOP             (stop),
    .BUSY             (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic s, input logic [15:0] r, input logic [7:0] m, input logic [63:0] v);
    req_seg = s;
    rep     = r;
    mode    = m;
    val     = v;
    update  = 1'b1;
    tick();
    update  = 1'b0;
  endtask

  task automatic pulse_loop_end();
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_segment", segment, 0);
    check("rst_swap", swap, 0);
    check("rst_stop", stop, 0);
    check("rst_busy", busy, 0);
    #11 rst_n = 1'b1;
    tick();

    // LOOP_END in RUN_INF changes nothing
    for (int i = 0; i < 3; i++) begin
      pulse_loop_end();
      check("idle_swap", swap, 0);
      check("idle_segment", segment, 0);
      check("idle_stop", stop, 0);
      tick();
    end

    // SYNC_IDX request to segment 1, infinite
    upd(1'b1, 16'hFFFF, 8'h00, 64'h0);
    check("sync_busy", busy, 1);
    check("sync_noswap0", swap, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("sync_wait_swap", swap, 0);
    end
    sync_zero = 1'b1;
    tick();
    sync_zero = 1'b0;
    check("sync_swap", swap, 1);
    check("sync_segment", segment, 1);
    check("sync_busy_clr", busy, 0);
    tick();
    check("sync_swap_width", swap, 0);
    check("sync_segment_hold", segment, 1);

    // EXT request to segment 0, REP=2
    upd(1'b0, 16'd2, 8'hF0, 64'h0);
    check("ext_busy", busy, 1);
    check("ext_seg_old", segment, 1);
    tick();
    tick();
    check("ext_wait_swap", swap, 0);
    pulse_loop_end();
    check("ext_swap", swap, 1);
    check("ext_segment", segment, 0);
    check("ext_busy_clr", busy, 0);
    check("ext_stop0", stop, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse_loop_end();
      check("fin_stop", stop, (i == 3) ? 1 : 0);
      tick();
    end
    pulse_loop_end();
    check("fin4_stop", stop, 1);
    check("fin4_swap", swap, 0);
    check("fin4_segment", segment, 0);

    // SYS_TIME ramp to 1000
    sys_time = 56'd990;
    upd(1'b1, 16'hFFFF, 8'h01, 64'd1000);
    check("time_busy", busy, 1);
    for (int t = 991; t <= 999; t++) begin
      sys_time = 56'(t);
      tick();
      check("time_early_swap", swap, 0);
    end
    sys_time = 56'd1000;
    tick();
    check("time_swap", swap, 1);
    check("time_segment", segment, 1);
    check("time_stop_clr", stop, 0);
    check("time_busy_clr", busy, 0);

    // SYS_TIME already in the past
    sys_time = 56'd2000;
    upd(1'b0, 16'hFFFF, 8'h01, 64'd1000);
    check("past_busy", busy, 1);
    check("past_swap_n1", swap, 0);
    tick();
    check("past_swap_n2", swap, 1);
    check("past_segment", segment, 0);

    // GPIO pin 2, already high at request time
    gpio = 4'h4;
    tick();
    upd(1'b1, 16'hFFFF, 8'h02, 64'd2);
`ifdef AUTD3_TRANSITION_GPIO_EN
    check("gpio_busy", busy, 1);
    tick();
    tick();
    check("gpio_level_swap", swap, 0);
    gpio = 4'h0;
    tick();
    check("gpio_fall_swap", swap, 0);
    gpio = 4'h4;
    tick();
    check("gpio_rise_swap", swap, 1);
    check("gpio_segment", segment, 1);
    exp_seg = 1'b1;
`else
    check("gpio_off_busy", busy, 0);
    gpio = 4'h0;
    tick();
    gpio = 4'h4;
    tick();
    check("gpio_off_swap", swap, 0);
    check("gpio_off_segment", segment, 0);
    check("gpio_off_busy2", busy, 0);
    exp_seg = 1'b0;
`endif

    // Replacement of a pending SYNC_IDX request in the trigger cycle
    upd(1'b0, 16'hFFFF, 8'h00, 64'h0);
    check("repl_busy", busy, 1);
    req_seg   = 1'b1;
    rep       = 16'd1;
    mode      = 8'h00;
    update    = 1'b1;
    sync_zero = 1'b1;
    tick();
    update    = 1'b0;
    sync_zero = 1'b0;
    check("repl_noswap", swap, 0);
    check("repl_busy2", busy, 1);
    check("repl_seg_hold", segment, exp_seg);
    sync_zero = 1'b1;
    tick();
    sync_zero = 1'b0;
    check("repl_swap", swap, 1);
    check("repl_segment", segment, 1);
    pulse_loop_end();
    check("repl_stop_1", stop, 0);
    tick();
    pulse_loop_end();
    check("repl_stop_2", stop, 1);

    // Unknown mode is discarded
    upd(1'b0, 16'hFFFF, 8'h07, 64'h0);
    check("unk_busy", busy, 0);
    check("unk_segment", segment, 1);
    check("unk_stop", stop, 1);
    check("unk_swap", swap, 0);

    // EXT while stopped fires on the first WAIT cycle
    upd(1'b0, 16'hFFFF, 8'hF0, 64'h0);
    check("extstop_busy", busy, 1);
    check("extstop_noswap", swap, 0);
    tick();
    check("extstop_swap", swap, 1);
    check("extstop_segment", segment, 0);
    check("extstop_stop_clr", stop, 0);
    tick();
    check("extstop_swap_width", swap, 0);

    // Reset during WAIT drops the request
    upd(1'b1, 16'hFFFF, 8'h00, 64'h0);
    check("rstwait_busy", busy, 1);
    #3 rst_n = 1'b0;
    #2;
    check("rstwait_busy_clr", busy, 0);
    check("rstwait_segment", segment, 0);
    #2 rst_n = 1'b1;
    sync_zero = 1'b1;
    tick();
    sync_zero = 1'b0;
    check("rstwait_swap", swap, 0);
    check("rstwait_busy2", busy, 0);
    check("rstwait_segment2", segment, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
